alu_issue_ctrl: RTL and testbench
=================================

// Module: alu_issue_ctrl
// PURPOSE
// - Initiator side of the ALU operation interface: accepts one instruction request (main-control aluop + funct + operands),
//   decodes it to the 3-bit ALU operation code, drives the ALU, captures result/zero, returns them on a response handshake.
// - Sits between multi-cycle datapath control and the combinational ALU; ALU responds within SETTLE_CYCLES clocks.
// PARAMETERS
// - WIDTH          32  operand/result width
// - SETTLE_CYCLES  1   cycles ALU inputs are held before capture; legal 1..15
// PORTS
// - clk           in   1      clock, rising edge
// - rst_n         in   1      asynchronous reset, active-low
// - req_valid     in   1      request present
// - req_ready     out  1      request accepted when valid&ready at clk edge
// - req_aluop     in   2      00 ADD (lw/sw/addi), 01 SUB (beq), 10 R-type use funct, 11 SLT (slti)
// - req_funct     in   6      R-type funct field
// - req_a         in   WIDTH  operand A
// - req_b         in   WIDTH  operand B
// - alu_a         out  WIDTH  to ALU operand a
// - alu_b         out  WIDTH  to ALU operand b
// - alu_operation out  3      to ALU: 000 NOTHING,001 ADD,010 SUB,011 AND,100 OR,101 SLT
// - alu_result    in   WIDTH  from ALU
// - alu_zero      in   1      from ALU (result==0)
// - rsp_valid     out  1      response held until rsp_ready
// - rsp_ready     in   1      response consumer ready
// - rsp_result    out  WIDTH  captured alu_result
// - rsp_zero      out  1      captured alu_zero
// - rsp_illegal   out  1      request decoded to NOTHING (unsupported funct)
// BEHAVIOUR
// - Reset (rst_n low, async): state IDLE, settle counter 0, all registered outputs 0, alu_operation 000;
//   req_ready forced 0 while rst_n low.
// - FSM IDLE -> EXEC -> RESP -> IDLE. Reset mid-operation aborts immediately; in-flight request discarded, no response.
// - IDLE: req_ready=1. On req_valid&req_ready: register req_a, req_b, decoded op, illegal flag; counter=0; -> EXEC.
// - Decode: aluop 00->001, 01->010, 11->101; aluop 10 by funct: 100000->001, 100010->010, 100100->011,
//   100101->100, 101010->101; any other funct -> 000 with illegal=1.
// - EXEC: req_ready=0; alu_a/alu_b/alu_operation driven from registers, stable all SETTLE_CYCLES cycles;
//   counter increments each cycle; on edge where counter==SETTLE_CYCLES-1 capture alu_result/alu_zero -> RESP.
// - Illegal request still goes through EXEC; ALU returns 0, so rsp_result=0, rsp_zero=1, rsp_illegal=1.
// - RESP: rsp_valid=1; rsp_result/zero/illegal stable until rsp_valid&rsp_ready edge -> IDLE, rsp_valid drops next cycle.
// - Outside EXEC: alu_a/alu_b hold last values, alu_operation=000 (ALU quiescent).
// - Latency: accept edge E0 -> rsp_valid high after edge E0+SETTLE_CYCLES; min throughput 1 req per SETTLE_CYCLES+2 clk.
// - No new request accepted in RESP or EXEC; req_* changes there ignored. rsp_ready high outside RESP ignored.
// - Arithmetic is in ALU; block does no width conversion; result captured bit-exact.
// CONFIGURATION
// - ALU_ISSUE_PERF_EN defined: adds outputs perf_ops (32, responses completed) and perf_illegal (16, illegal
//   responses completed); both increment on rsp handshake edge, wrap at max, reset to 0.
// - Undefined: ports and counters absent; all other behaviour identical.
// TESTING
// - Reset then aluop=10 funct=100000 a=5 b=7, rsp_ready=1 -> alu_operation=001 in EXEC, rsp_result=12, rsp_zero=0, illegal=0.
// - aluop=01 a=9 b=9 -> alu_operation=010, rsp_result=0, rsp_zero=1; aluop=11 a=3 b=8 -> op 101, rsp_result=1.
// - aluop=10 funct=000000 a=1 b=1 -> op 000, rsp_result=0, rsp_zero=1, rsp_illegal=1 (perf_illegal=1 if _PERF_EN).
// - rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_result stable, req_ready=0, second req_valid not accepted.
// - SETTLE_CYCLES=3, aluop=10 funct=100101 a=0xF0 b=0x0F -> rsp_valid 3 cycles after accept, rsp_result=0xFF.
// - rst_n pulsed low during EXEC -> rsp_valid never asserts, alu_operation=000, req_ready=1 after release.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
//
// Initiator side of the ALU operation interface. Takes one instruction
// request (main-control aluop + funct + operands), decodes it to the 3-bit
// ALU operation code and drives the combinational ALU. Inputs are held for
// SETTLE_CYCLES clocks, then result/zero are captured and returned on a
// valid/ready response handshake.
//
// Parameters
//   WIDTH          operand/result width
//   SETTLE_CYCLES  cycles the ALU inputs are held before capture (1..15)
//
// Ports
//   clk, rst_n                  clock (rising edge), async active-low reset
//   req_valid/req_ready         request handshake
//   req_aluop, req_funct        main-control aluop and R-type funct field
//   req_a, req_b                operands
//   alu_a, alu_b, alu_operation drive to the ALU (operation 000 = quiescent)
//   alu_result, alu_zero        from the ALU
//   rsp_valid/rsp_ready         response handshake
//   rsp_result, rsp_zero        captured ALU outputs
//   rsp_illegal                 request decoded to NOTHING
//
// Optional feature (macro ALU_ISSUE_PERF_EN)
//   perf_ops      responses completed (32 bit, wraps)
//   perf_illegal  illegal responses completed (16 bit, wraps)
//
// States
//   state  | meaning
//   IDLE   | ready for a request, ALU quiescent
//   EXEC   | ALU inputs held, settle counter running
//   RESP   | captured response presented until rsp_ready
// ---------------------------------------------------------------------------
module alu_issue_ctrl #(
    parameter int WIDTH         = 32,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_aluop,
    input  logic [5:0]       req_funct,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_operation,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_illegal
`ifdef ALU_ISSUE_PERF_EN
    ,
    output logic [31:0]      perf_ops,
    output logic [15:0]      perf_illegal
`endif
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("alu_issue_ctrl: SETTLE_CYCLES must be 1..15");
    end

    localparam logic [2:0] OP_NOTHING = 3'b000;
    localparam logic [2:0] OP_ADD     = 3'b001;
    localparam logic [2:0] OP_SUB     = 3'b010;
    localparam logic [2:0] OP_AND     = 3'b011;
    localparam logic [2:0] OP_OR      = 3'b100;
    localparam logic [2:0] OP_SLT     = 3'b101;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] settle_cnt;
    logic       illegal_reg;
    logic [2:0] dec_op;
    logic       dec_illegal;

    // aluop 10 defers to the funct field; unknown functs map to NOTHING and
    // are flagged so the consumer can tell them apart from a genuine zero.
    always_comb begin
        dec_op      = OP_NOTHING;
        dec_illegal = 1'b0;
        case (req_aluop)
            2'b00: dec_op = OP_ADD;
            2'b01: dec_op = OP_SUB;
            2'b11: dec_op = OP_SLT;
            default: begin
                case (req_funct)
                    6'b100000: dec_op = OP_ADD;
                    6'b100010: dec_op = OP_SUB;
                    6'b100100: dec_op = OP_AND;
                    6'b100101: dec_op = OP_OR;
                    6'b101010: dec_op = OP_SLT;
                    default:   dec_illegal = 1'b1;
                endcase
            end
        endcase
    end

    // Combinational so it drops the instant reset asserts and rises as soon
    // as reset releases into IDLE.
    assign req_ready = rst_n && (state == S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            settle_cnt    <= '0;
            illegal_reg   <= 1'b0;
            alu_a         <= '0;
            alu_b         <= '0;
            alu_operation <= OP_NOTHING;
            rsp_valid     <= 1'b0;
            rsp_result    <= '0;
            rsp_zero      <= 1'b0;
            rsp_illegal   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        alu_a         <= req_a;
                        alu_b         <= req_b;
                        alu_operation <= dec_op;
                        illegal_reg   <= dec_illegal;
                        settle_cnt    <= '0;
                        state         <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        rsp_result    <= alu_result;
                        rsp_zero      <= alu_zero;
                        rsp_illegal   <= illegal_reg;
                        rsp_valid     <= 1'b1;
                        alu_operation <= OP_NOTHING;
                        state         <= S_RESP;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef ALU_ISSUE_PERF_EN
    logic rsp_fire;
    assign rsp_fire = rsp_valid && rsp_ready && (state == S_RESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_ops     <= '0;
            perf_illegal <= '0;
        end else if (rsp_fire) begin
            perf_ops <= perf_ops + 32'd1;
            if (rsp_illegal) begin
                perf_illegal <= perf_illegal + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- DUT 1: SETTLE_CYCLES = 1 ----------------
    logic        req_valid1 = 1'b0, req_ready1;
    logic [1:0]  req_aluop1 = '0;
    logic [5:0]  req_funct1 = '0;
    logic [31:0] req_a1 = '0, req_b1 = '0;
    logic [31:0] alu_a1, alu_b1, alu_result1, rsp_result1;
    logic [2:0]  alu_operation1;
    logic        alu_zero1, rsp_valid1, rsp_zero1, rsp_illegal1;
    logic        rsp_ready1 = 1'b0;

    // ---------------- DUT 3: SETTLE_CYCLES = 3 ----------------
    logic        req_valid3 = 1'b0, req_ready3;
    logic [1:0]  req_aluop3 = '0;
    logic [5:0]  req_funct3 = '0;
    logic [31:0] req_a3 = '0, req_b3 = '0;
    logic [31:0] alu_a3, alu_b3, alu_result3, rsp_result3;
    logic [2:0]  alu_operation3;
    logic        alu_zero3, rsp_valid3, rsp_zero3, rsp_illegal3;
    logic        rsp_ready3 = 1'b0;

`ifdef ALU_ISSUE_PERF_EN
    logic [31:0] perf_ops1, perf_ops3;
    logic [15:0] perf_illegal1, perf_illegal3;
    int          exp_ops = 0;
    int          exp_ill = 0;
`endif

    // Behavioural ALU attached to each DUT.
    function automatic logic [31:0] alu_fn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'b001:  return a + b;
            3'b010:  return a - b;
            3'b011:  return a & b;
            3'b100:  return a | b;
            3'b101:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    assign alu_result1 = alu_fn(alu_operation1, alu_a1, alu_b1);
    assign alu_zero1   = (alu_result1 == 32'd0);
    assign alu_result3 = alu_fn(alu_operation3, alu_a3, alu_b3);
    assign alu_zero3   = (alu_result3 == 32'd0);

    alu_issue_ctrl #(.WIDTH(32), .SETTLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid1), .req_ready(req_ready1),
        .req_aluop(req_aluop1), .req_funct(req_funct1),
        .req_a(req_a1), .req_b(req_b1),
        .alu_a(alu_a1), .alu_b(alu_b1), .alu_operation(alu_operation1),
        .alu_result(alu_result1), .alu_zero(alu_zero1),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
        .rsp_result(rsp_result1), .rsp_zero(rsp_zero1), .rsp_illegal(rsp_illegal1)
`ifdef ALU_ISSUE_PERF_EN
        , .perf_ops(perf_ops1), .perf_illegal(perf_illegal1)
`endif
    );

    alu_issue_ctrl #(.WIDTH(32), .SETTLE_CYCLES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid3), .req_ready(req_ready3),
        .req_aluop(req_aluop3), .req_funct(req_funct3),
        .req_a(req_a3), .req_b(req_b3),
        .alu_a(alu_a3), .alu_b(alu_b3), .alu_operation(alu_operation3),
        .alu_result(alu_result3), .alu_zero(alu_zero3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
        .rsp_result(rsp_result3), .rsp_zero(rsp_zero3), .rsp_illegal(rsp_illegal3)
`ifdef ALU_ISSUE_PERF_EN
        , .perf_ops(perf_ops3), .perf_illegal(perf_illegal3)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: instruction semantics straight from the opcode tables.
    task automatic ref_model(input logic [1:0] aluop, input logic [5:0] funct,
                             input logic [31:0] a, input logic [31:0] b,
                             output logic [2:0] op, output logic [31:0] res,
                             output logic zero, output logic ill);
        string mn;
        if (aluop == 2'b00) mn = "add";
        else if (aluop == 2'b01) mn = "sub";
        else if (aluop == 2'b11) mn = "slt";
        else if (funct == 6'd32) mn = "add";
        else if (funct == 6'd34) mn = "sub";
        else if (funct == 6'd36) mn = "and";
        else if (funct == 6'd37) mn = "or";
        else if (funct == 6'd42) mn = "slt";
        else mn = "bad";
        ill = 1'b0;
        case (mn)
            "add":   begin op = 3'd1; res = a + b; end
            "sub":   begin op = 3'd2; res = a - b; end
            "and":   begin op = 3'd3; res = a & b; end
            "or":    begin op = 3'd4; res = a | b; end
            "slt":   begin op = 3'd5; res = (int'(a) < int'(b)) ? 32'd1 : 32'd0; end
            default: begin op = 3'd0; res = 32'd0; ill = 1'b1; end
        endcase
        zero = (res == 32'd0);
    endtask

    // One full transaction on DUT 1; caller sits #1 after a rising edge.
    task automatic run_txn(input logic [1:0] aluop, input logic [5:0] funct,
                           input logic [31:0] a, input logic [31:0] b, input int delay,
                           input logic [2:0] eop, input logic [31:0] eres,
                           input logic ezero, input logic eill);
        int lat;
        chk("ready_idle", 32'(req_ready1), 32'd1);
        req_aluop1 = aluop; req_funct1 = funct; req_a1 = a; req_b1 = b;
        req_valid1 = 1'b1;
        rsp_ready1 = 1'b0;
        @(posedge clk); #1;
        req_valid1 = 1'b0;
        chk("ready_exec", 32'(req_ready1), 32'd0);
        chk("op_exec", 32'(alu_operation1), 32'(eop));
        chk("alu_a_exec", alu_a1, a);
        chk("alu_b_exec", alu_b1, b);
        lat = 0;
        while (rsp_valid1 !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 32'(lat), 32'd1);
        chk("rsp_result", rsp_result1, eres);
        chk("rsp_zero", 32'(rsp_zero1), 32'(ezero));
        chk("rsp_illegal", 32'(rsp_illegal1), 32'(eill));
        chk("op_quiet_resp", 32'(alu_operation1), 32'd0);
        for (int i = 0; i < delay; i++) begin
            // A competing request while the response is pending must be ignored.
            req_valid1 = 1'b1; req_a1 = $urandom; req_aluop1 = 2'b00;
            @(posedge clk); #1;
            chk("hold_valid", 32'(rsp_valid1), 32'd1);
            chk("hold_result", rsp_result1, eres);
            chk("hold_ready", 32'(req_ready1), 32'd0);
        end
        req_valid1 = 1'b0;
        if (delay > 0) chk("hold_alu_a", alu_a1, a);
        rsp_ready1 = 1'b1;
        @(posedge clk); #1;
        rsp_ready1 = 1'b0;
        chk("valid_drop", 32'(rsp_valid1), 32'd0);
        chk("ready_back", 32'(req_ready1), 32'd1);
`ifdef ALU_ISSUE_PERF_EN
        exp_ops++;
        if (eill) exp_ill++;
        chk("perf_ops", perf_ops1, 32'(exp_ops));
        chk("perf_illegal", 32'(perf_illegal1), 32'(exp_ill));
`endif
    endtask

    typedef struct {
        logic [1:0]  aluop;
        logic [5:0]  funct;
        logic [31:0] a;
        logic [31:0] b;
        int          delay;
        logic [2:0]  op;
        logic [31:0] res;
        logic        zero;
        logic        ill;
    } vec_t;

    vec_t vecs[11];

    initial begin
        logic [5:0]  legal_f[5];
        logic [1:0]  r_aluop;
        logic [5:0]  r_funct;
        logic [31:0] r_a, r_b, m_res;
        logic [2:0]  m_op;
        logic        m_zero, m_ill;
        int          lat;
        logic        seen_valid;
        logic        op_stable;

        vecs[0]  = '{2'b10, 6'b100000, 32'd5,        32'd7,          0, 3'b001, 32'd12,     1'b0, 1'b0};
        vecs[1]  = '{2'b01, 6'b000000, 32'd9,        32'd9,          0, 3'b010, 32'd0,      1'b1, 1'b0};
        vecs[2]  = '{2'b11, 6'b000000, 32'd3,        32'd8,          0, 3'b101, 32'd1,      1'b0, 1'b0};
        vecs[3]  = '{2'b10, 6'b000000, 32'd1,        32'd1,          0, 3'b000, 32'd0,      1'b1, 1'b1};
        vecs[4]  = '{2'b10, 6'b100010, 32'd20,       32'd5,          5, 3'b010, 32'd15,     1'b0, 1'b0};
        vecs[5]  = '{2'b10, 6'b100100, 32'h0000F0F0, 32'h00000FF0,   0, 3'b011, 32'h000000F0, 1'b0, 1'b0};
        vecs[6]  = '{2'b10, 6'b101010, 32'hFFFFFFFF, 32'd1,          1, 3'b101, 32'd1,      1'b0, 1'b0};
        vecs[7]  = '{2'b00, 6'b111111, 32'hFFFFFFFF, 32'd1,          0, 3'b001, 32'd0,      1'b1, 1'b0};
        vecs[8]  = '{2'b11, 6'b000000, 32'd5,        32'hFFFFFFFE,   0, 3'b101, 32'd0,      1'b1, 1'b0};
        vecs[9]  = '{2'b10, 6'b100101, 32'd0,        32'd0,          0, 3'b100, 32'd0,      1'b1, 1'b0};
        vecs[10] = '{2'b10, 6'b111111, 32'd7,        32'd3,          2, 3'b000, 32'd0,      1'b1, 1'b1};

        legal_f[0] = 6'b100000; legal_f[1] = 6'b100010; legal_f[2] = 6'b100100;
        legal_f[3] = 6'b100101; legal_f[4] = 6'b101010;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(req_ready1), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid1), 32'd0);
        chk("rst_alu_op", 32'(alu_operation1), 32'd0);
        chk("rst_alu_a", alu_a1, 32'd0);
        chk("rst_rsp_result", rsp_result1, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_release_ready", 32'(req_ready1), 32'd1);
        @(posedge clk); #1;

        // Directed vectors
        for (int i = 0; i < 11; i++) begin
            run_txn(vecs[i].aluop, vecs[i].funct, vecs[i].a, vecs[i].b, vecs[i].delay,
                    vecs[i].op, vecs[i].res, vecs[i].zero, vecs[i].ill);
        end

        // Randomised transactions against the reference model
        for (int i = 0; i < 40; i++) begin
            r_aluop = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) r_funct = 6'($urandom);
            else r_funct = legal_f[$urandom_range(0, 4)];
            r_a = $urandom;
            r_b = ($urandom_range(0, 4) == 0) ? r_a : $urandom;
            if ($urandom_range(0, 2) == 0) r_a = 32'($urandom_range(0, 15));
            ref_model(r_aluop, r_funct, r_a, r_b, m_op, m_res, m_zero, m_ill);
            run_txn(r_aluop, r_funct, r_a, r_b, $urandom_range(0, 2), m_op, m_res, m_zero, m_ill);
        end

        // SETTLE_CYCLES = 3: OR of 0xF0 and 0x0F
        req_aluop3 = 2'b10; req_funct3 = 6'b100101; req_a3 = 32'hF0; req_b3 = 32'h0F;
        req_valid3 = 1'b1;
        @(posedge clk); #1;
        req_valid3 = 1'b0;
        chk("s3_op_exec", 32'(alu_operation3), 32'd4);
        lat = 0;
        op_stable = 1'b1;
        while (rsp_valid3 !== 1'b1 && lat < 20) begin
            if (alu_operation3 !== 3'b100) op_stable = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        chk("s3_latency", 32'(lat), 32'd3);
        chk("s3_op_stable", 32'(op_stable), 32'd1);
        chk("s3_result", rsp_result3, 32'hFF);
        chk("s3_zero", 32'(rsp_zero3), 32'd0);
        rsp_ready3 = 1'b1;
        @(posedge clk); #1;
        rsp_ready3 = 1'b0;
        chk("s3_valid_drop", 32'(rsp_valid3), 32'd0);

        // Reset pulsed during EXEC aborts the request
        req_aluop3 = 2'b00; req_a3 = 32'd4; req_b3 = 32'd4;
        req_valid3 = 1'b1;
        @(posedge clk); #1;
        req_valid3 = 1'b0;
        rsp_ready3 = 1'b1;
        @(posedge clk); #1;
        chk("abort_in_exec", 32'(alu_operation3), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_ready_low", 32'(req_ready3), 32'd0);
        chk("abort_op_quiet", 32'(alu_operation3), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("abort_ready_after", 32'(req_ready3), 32'd1);
        seen_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (rsp_valid3 !== 1'b0) seen_valid = 1'b1;
        end
        rsp_ready3 = 1'b0;
        chk("abort_no_rsp", 32'(seen_valid), 32'd0);
        chk("abort_op_idle", 32'(alu_operation3), 32'd0);
        chk("abort_ready_idle", 32'(req_ready3), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
